// File: rtl/isa_defs_pkg.sv
// ISA definitions shared by fetch, decode and execute: opcodes, ALU ops and the decoded bundle.
// Bundle widths are fixed here; the decode stage parameters must match these values.
package isa_defs_pkg;

  localparam int DEC_XLEN       = 32;
  localparam int DEC_REG_ADDR_W = 3;
  localparam int DEC_IMM_W      = 16;
  localparam int OPC_W          = 6;

  typedef enum logic [OPC_W-1:0] {
    OPC_NOP   = 6'd0,
    OPC_ADD   = 6'd1,
    OPC_SUB   = 6'd2,
    OPC_ADDI  = 6'd3,
    OPC_LOAD  = 6'd4,
    OPC_STORE = 6'd5,
    OPC_AND   = 6'd6,
    OPC_OR    = 6'd7,
    OPC_ANDI  = 6'd8,
    OPC_BEQ   = 6'd9
  } opcode_e;

  typedef enum logic [2:0] {
    ALU_OP_NONE = 3'd0,
    ALU_OP_ADD  = 3'd1,
    ALU_OP_SUB  = 3'd2,
    ALU_OP_AND  = 3'd3,
    ALU_OP_OR   = 3'd4
  } alu_op_e;

  // opcode is kept raw so illegal encodings reach execute unchanged
  typedef struct packed {
    logic [OPC_W-1:0]          opcode;
    logic [DEC_REG_ADDR_W-1:0] rd;
    logic [DEC_REG_ADDR_W-1:0] rs1;
    logic [DEC_REG_ADDR_W-1:0] rs2;
    logic [DEC_XLEN-1:0]       imm;
    alu_op_e                   alu_op;
    logic                      reg_we;
    logic                      mem_re;
    logic                      mem_we;
    logic                      use_imm;
    logic                      is_branch;
    logic                      illegal;
  } dec_t;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } skid_state_e;

endpackage

// File: rtl/instr_decode_comb.sv
// Combinational decode of one 32-bit instruction word into a dec_t bundle; zero latency, no flow control.
// STORE and BEQ read their second source from the rd field and write no register.
module instr_decode_comb
  import isa_defs_pkg::*;
(
  input  logic [31:0] i_instr,
  output dec_t        o_dec
);

  localparam int W      = DEC_REG_ADDR_W;
  localparam int RD_HI  = 25;
  localparam int RS1_HI = 25 - W;
  localparam int RS2_HI = 25 - 2 * W;

  logic [OPC_W-1:0]     w_opc;
  logic [W-1:0]         w_rd_f;
  logic [W-1:0]         w_rs1_f;
  logic [W-1:0]         w_rs2_f;
  logic [DEC_IMM_W-1:0] w_imm_f;
  logic [DEC_XLEN-1:0]  w_imm_sx;
  logic [DEC_XLEN-1:0]  w_imm_zx;
  logic                 w_unused;

  assign w_opc    = i_instr[31:26];
  assign w_rd_f   = i_instr[RD_HI -: W];
  assign w_rs1_f  = i_instr[RS1_HI -: W];
  assign w_rs2_f  = i_instr[RS2_HI -: W];
  assign w_imm_f  = i_instr[RS2_HI -: DEC_IMM_W];
  assign w_imm_sx = DEC_XLEN'($signed(w_imm_f));
  assign w_imm_zx = DEC_XLEN'(w_imm_f);
  // low bits below the immediate carry no meaning in any format
  assign w_unused = ^i_instr;

  always_comb begin
    o_dec        = '0;
    o_dec.opcode = w_opc;
    o_dec.rd     = w_rd_f;
    o_dec.rs1    = w_rs1_f;
    o_dec.rs2    = w_rs2_f;
    o_dec.alu_op = ALU_OP_NONE;
    case (w_opc)
      OPC_NOP: ;
      OPC_ADD: begin
        o_dec.alu_op = ALU_OP_ADD;
        o_dec.reg_we = 1'b1;
      end
      OPC_SUB: begin
        o_dec.alu_op = ALU_OP_SUB;
        o_dec.reg_we = 1'b1;
      end
      OPC_ADDI: begin
        o_dec.alu_op  = ALU_OP_ADD;
        o_dec.reg_we  = 1'b1;
        o_dec.use_imm = 1'b1;
        o_dec.imm     = w_imm_sx;
      end
      OPC_LOAD: begin
        o_dec.alu_op  = ALU_OP_ADD;
        o_dec.reg_we  = 1'b1;
        o_dec.mem_re  = 1'b1;
        o_dec.use_imm = 1'b1;
        o_dec.imm     = w_imm_sx;
      end
      OPC_STORE: begin
        o_dec.rd      = '0;
        o_dec.rs2     = w_rd_f;
        o_dec.alu_op  = ALU_OP_ADD;
        o_dec.mem_we  = 1'b1;
        o_dec.use_imm = 1'b1;
        o_dec.imm     = w_imm_sx;
      end
      OPC_AND: begin
        o_dec.alu_op = ALU_OP_AND;
        o_dec.reg_we = 1'b1;
      end
      OPC_OR: begin
        o_dec.alu_op = ALU_OP_OR;
        o_dec.reg_we = 1'b1;
      end
      OPC_ANDI: begin
        o_dec.alu_op  = ALU_OP_AND;
        o_dec.reg_we  = 1'b1;
        o_dec.use_imm = 1'b1;
        o_dec.imm     = w_imm_zx;
      end
      OPC_BEQ: begin
        o_dec.rd        = '0;
        o_dec.rs2       = w_rd_f;
        o_dec.alu_op    = ALU_OP_SUB;
        o_dec.is_branch = 1'b1;
        o_dec.imm       = w_imm_sx;
      end
      default: o_dec.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_decode_stage.sv
// Registered decode stage with skid buffer: 1-cycle latency, full throughput.
// in_ready comes only from skid occupancy; output holds stable while out_ready is low.
module instr_decode_stage
  import isa_defs_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 3,
  parameter int IMM_W      = 16,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  output logic             out_valid,
  input  logic             out_ready,
  output dec_t             out_dec,
  output logic [CNT_W-1:0] illegal_cnt
);

  if ((2 * REG_ADDR_W + IMM_W > 26) || (IMM_W > XLEN)) begin : g_bad_widths
    $error("instr_decode_stage: field widths do not fit the instruction word");
  end
  if ((XLEN != DEC_XLEN) || (REG_ADDR_W != DEC_REG_ADDR_W) || (IMM_W != DEC_IMM_W)) begin : g_pkg_mismatch
    $error("instr_decode_stage: parameters differ from isa_defs_pkg bundle widths");
  end

  skid_state_e      r_state;
  skid_state_e      w_state_nxt;
  dec_t             r_out_dec;
  dec_t             r_skid_dec;
  dec_t             w_dec;
  logic [CNT_W-1:0] r_illegal_cnt;
  logic             w_accept;
  logic             w_load_out;
  logic             w_load_skid;
  logic             w_skid_to_out;

  instr_decode_comb u_decode (
    .i_instr (in_instr),
    .o_dec   (w_dec)
  );

  assign in_ready    = (r_state != ST_TWO);
  assign out_valid   = (r_state != ST_EMPTY);
  assign w_accept    = in_valid && in_ready;
  assign out_dec     = r_out_dec;
  assign illegal_cnt = r_illegal_cnt;

  always_comb begin
    w_state_nxt   = r_state;
    w_load_out    = 1'b0;
    w_load_skid   = 1'b0;
    w_skid_to_out = 1'b0;
    case (r_state)
      ST_EMPTY: begin
        if (w_accept) begin
          w_load_out  = 1'b1;
          w_state_nxt = ST_ONE;
        end
      end
      ST_ONE: begin
        if (w_accept && out_ready) begin
          w_load_out = 1'b1;
        end else if (w_accept) begin
          w_load_skid = 1'b1;
          w_state_nxt = ST_TWO;
        end else if (out_ready) begin
          w_state_nxt = ST_EMPTY;
        end
      end
      ST_TWO: begin
        if (out_ready) begin
          w_skid_to_out = 1'b1;
          w_state_nxt   = ST_ONE;
        end
      end
      default: w_state_nxt = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_EMPTY;
      r_out_dec  <= '0;
      r_skid_dec <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_load_out) begin
        r_out_dec <= w_dec;
      end else if (w_skid_to_out) begin
        r_out_dec <= r_skid_dec;
      end
      if (w_load_skid) begin
        r_skid_dec <= w_dec;
      end
    end
  end

  // saturates at all-ones so a flood of bad opcodes never reads as a small count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_illegal_cnt <= '0;
    end else if (w_accept && w_dec.illegal && (r_illegal_cnt != '1)) begin
      r_illegal_cnt <= r_illegal_cnt + 1'b1;
    end
  end

endmodule
